param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_ram.sv | 30 +++
 rtl/param_fifo.sv | 141 ++++++++++++++
 tb/tb_param_fifo.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the parameterised FIFO: default geometry and read-mode encodings.
package fifo_pkg;

    localparam int unsigned FIFO_DEF_WIDTH = 16;
    localparam int unsigned FIFO_DEF_DEPTH = 8;

    localparam int unsigned FIFO_MODE_REG  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// Storage array for param_fifo: synchronous write, asynchronous read, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned width     = FIFO_DEF_WIDTH,
    parameter int unsigned adr_width = $clog2(FIFO_DEF_DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [adr_width-1:0] wr_addr,
    input  logic [width-1:0]     wr_data,
    input  logic [adr_width-1:0] rd_addr,
    output logic [width-1:0]     rd_data_c
);

    localparam int unsigned ENTRIES = 32'(1) << adr_width;

    logic [width-1:0] mem_q [ENTRIES];

    // Write port: one word per accepted write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port is combinational so the head word can be picked up within the cycle
    assign rd_data_c = mem_q[rd_addr];

endmodule : fifo_ram

// File: rtl/param_fifo.sv
// Synchronous FIFO with occupancy flags, sticky error flags and registered or FWFT read data.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned width     = FIFO_DEF_WIDTH,
    parameter int unsigned depth     = FIFO_DEF_DEPTH,
    parameter int unsigned adr_width = $clog2(depth),
    parameter int unsigned af_thr    = depth - 2,
    parameter int unsigned ae_thr    = 1,
    parameter int unsigned fwft      = FIFO_MODE_REG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [width-1:0]     data_in,
    input  logic                 we,
    input  logic                 re,
    input  logic                 err_clr,
    output logic [width-1:0]     data_out,
    output logic                 data_valid,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [adr_width:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned PW        = adr_width + 1;
    localparam bit          FWFT_MODE = (fwft == FIFO_MODE_FWFT);

    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [PW-1:0]        count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 af_q, af_d;
    logic                 ae_q, ae_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic [width-1:0]     dout_q, dout_d;
    logic                 valid_q, valid_d;

    logic                 wr_acc_c;
    logic                 rd_acc_c;
    logic                 ram_we_c;
    logic [adr_width-1:0] ram_raddr_c;
    logic [width-1:0]     ram_rdata_c;

    // Accept decisions use only the registered full/empty state
    always_comb begin
        wr_acc_c = we && !full_q;
        rd_acc_c = re && !empty_q;
        ram_we_c = wr_acc_c && !rst;
    end

    // FWFT looks ahead at the post-edge head; registered mode reads the current head
    assign ram_raddr_c = FWFT_MODE ? rptr_d[adr_width-1:0] : rptr_q[adr_width-1:0];

    fifo_ram #(
        .width     (width),
        .adr_width (adr_width)
    ) u_ram (
        .clk       (clk),
        .wr_en     (ram_we_c),
        .wr_addr   (wptr_q[adr_width-1:0]),
        .wr_data   (data_in),
        .rd_addr   (ram_raddr_c),
        .rd_data_c (ram_rdata_c)
    );

    // Next pointers, occupancy flags, sticky errors and read data
    always_comb begin
        wptr_d      = wptr_q + PW'(wr_acc_c);
        rptr_d      = rptr_q + PW'(rd_acc_c);
        count_d     = wptr_d - rptr_d;
        full_d      = (wptr_d[PW-1] != rptr_d[PW-1]) &&
                      (wptr_d[adr_width-1:0] == rptr_d[adr_width-1:0]);
        empty_d     = (wptr_d == rptr_d);
        af_d        = (32'(count_d) >= af_thr);
        ae_d        = (32'(count_d) <= ae_thr);
        overflow_d  = (we && full_q)  ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
        underflow_d = (re && empty_q) ? 1'b1 : (err_clr ? 1'b0 : underflow_q);
        dout_d      = dout_q;
        valid_d     = 1'b0;
        if (FWFT_MODE) begin
            // A write landing in the slot that becomes head is not in the array yet
            if (wr_acc_c && (wptr_q[adr_width-1:0] == rptr_d[adr_width-1:0])) begin
                dout_d = data_in;
            end else begin
                dout_d = ram_rdata_c;
            end
            valid_d = !empty_d;
        end else begin
            if (rd_acc_c) begin
                dout_d = ram_rdata_c;
            end
            valid_d = rd_acc_c;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
        end
    end

    assign data_out     = dout_q;
    assign data_valid   = valid_q;
    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule : param_fifo

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: registered-mode and FWFT instances share stimulus, checked against a queue model.
module tb_param_fifo;

    localparam int W = 16;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst, we, re, err_clr;
    logic [W-1:0]  data_in;

    logic [W-1:0]  r_dout, f_dout;
    logic          r_vld, f_vld, r_full, f_full, r_empty, f_empty;
    logic          r_af, f_af, r_ae, f_ae, r_ovf, f_ovf, r_unf, f_unf;
    logic [3:0]    r_count, f_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0]  mq[$];
    logic          m_ovf, m_unf, m_vreg;
    logic [W-1:0]  m_dreg;

    always #5 clk = ~clk;

    param_fifo #(.width(W), .depth(D), .af_thr(6), .ae_thr(1), .fwft(0)) dut_reg (
        .clk(clk), .rst(rst), .data_in(data_in), .we(we), .re(re), .err_clr(err_clr),
        .data_out(r_dout), .data_valid(r_vld), .fifo_full(r_full), .fifo_empty(r_empty),
        .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
        .overflow(r_ovf), .underflow(r_unf)
    );

    param_fifo #(.width(W), .depth(D), .af_thr(6), .ae_thr(1), .fwft(1)) dut_fwft (
        .clk(clk), .rst(rst), .data_in(data_in), .we(we), .re(re), .err_clr(err_clr),
        .data_out(f_dout), .data_valid(f_vld), .fifo_full(f_full), .fifo_empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    typedef struct {
        logic         rst, we, re, clr;
        logic [W-1:0] din;
        int           cnt;
        logic         vld;
        logic [W-1:0] dout;
        logic         ovf, unf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare both instances against the queue model
    task automatic cmp_model();
        int sz;
        sz = mq.size();
        chk("r_count", 32'(r_count), sz);
        chk("f_count", 32'(f_count), sz);
        chk("r_full",  32'(r_full),  32'(sz == D));
        chk("f_full",  32'(f_full),  32'(sz == D));
        chk("r_empty", 32'(r_empty), 32'(sz == 0));
        chk("f_empty", 32'(f_empty), 32'(sz == 0));
        chk("r_af",    32'(r_af),    32'(sz >= 6));
        chk("f_af",    32'(f_af),    32'(sz >= 6));
        chk("r_ae",    32'(r_ae),    32'(sz <= 1));
        chk("f_ae",    32'(f_ae),    32'(sz <= 1));
        chk("r_ovf",   32'(r_ovf),   32'(m_ovf));
        chk("f_ovf",   32'(f_ovf),   32'(m_ovf));
        chk("r_unf",   32'(r_unf),   32'(m_unf));
        chk("f_unf",   32'(f_unf),   32'(m_unf));
        chk("r_vld",   32'(r_vld),   32'(m_vreg));
        chk("r_dout",  32'(r_dout),  32'(m_dreg));
        chk("f_vld",   32'(f_vld),   32'(sz != 0));
        if (sz != 0) chk("f_dout", 32'(f_dout), 32'(mq[0]));
    endtask

    // Apply one cycle of inputs, advance the model, then compare
    task automatic step(input logic i_rst, input logic i_we, input logic i_re,
                        input logic i_clr, input logic [W-1:0] i_din);
        logic full, empty;
        rst = i_rst; we = i_we; re = i_re; err_clr = i_clr; data_in = i_din;
        @(posedge clk);
        if (i_rst) begin
            mq.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_vreg = 1'b0; m_dreg = '0;
        end else begin
            full  = (mq.size() == D);
            empty = (mq.size() == 0);
            m_ovf = (i_we && full)  || (m_ovf && !i_clr);
            m_unf = (i_re && empty) || (m_unf && !i_clr);
            m_vreg = 1'b0;
            if (i_re && !empty) begin
                m_dreg = mq.pop_front();
                m_vreg = 1'b1;
            end
            if (i_we && !full) mq.push_back(i_din);
        end
        #1;
        cmp_model();
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic c,
                                input logic [W-1:0] din, input int cnt, input logic vld,
                                input logic [W-1:0] dout, input logic ovf, input logic unf);
        vec_t v;
        v.rst = r; v.we = w; v.re = rd; v.clr = c; v.din = din;
        v.cnt = cnt; v.vld = vld; v.dout = dout; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; err_clr = 1'b0; data_in = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_vreg = 1'b0; m_dreg = '0;

        // Directed table: fill, overflow, clear, drain, underflow, set-beats-clear
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(0, 1, 0, 0, W'(i), i, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 16'hDEAD, 8, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 8, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 8, 0, 16'h0000, 0, 0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 8 - k, 1, W'(k), 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0008, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 0, 0, 16'h0008, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 0, 16'h0008, 0, 0));

        foreach (tbl[n]) begin
            step(tbl[n].rst, tbl[n].we, tbl[n].re, tbl[n].clr, tbl[n].din);
            chk($sformatf("tbl_count[%0d]", n), 32'(r_count), tbl[n].cnt);
            chk($sformatf("tbl_full[%0d]", n),  32'(r_full),  32'(tbl[n].cnt == 8));
            chk($sformatf("tbl_empty[%0d]", n), 32'(r_empty), 32'(tbl[n].cnt == 0));
            chk($sformatf("tbl_af[%0d]", n),    32'(r_af),    32'(tbl[n].cnt >= 6));
            chk($sformatf("tbl_ae[%0d]", n),    32'(r_ae),    32'(tbl[n].cnt <= 1));
            chk($sformatf("tbl_vld[%0d]", n),   32'(r_vld),   32'(tbl[n].vld));
            chk($sformatf("tbl_dout[%0d]", n),  32'(r_dout),  32'(tbl[n].dout));
            chk($sformatf("tbl_ovf[%0d]", n),   32'(r_ovf),   32'(tbl[n].ovf));
            chk($sformatf("tbl_unf[%0d]", n),   32'(r_unf),   32'(tbl[n].unf));
        end

        // Wrap: 3 preloaded words, then 12 cycles of simultaneous write and read
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, W'(16'h0100 + i));
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 0, W'(16'h0103 + i));
            chk("wrap_count", 32'(r_count), 3);
            chk("wrap_rdout", 32'(r_dout), 32'(16'h0100 + i));
            chk("wrap_rvld",  32'(r_vld), 1);
            chk("wrap_fdout", 32'(f_dout), 32'(16'h0101 + i));
        end

        // FWFT: single word visible before any read, popped by re
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, 16'h00AA);
        chk("fwft_dout",  32'(f_dout), 32'h00AA);
        chk("fwft_vld",   32'(f_vld), 1);
        chk("fwft_empty", 32'(f_empty), 0);
        chk("reg_vld_nr", 32'(r_vld), 0);
        step(0, 0, 1, 0, '0);
        chk("fwft_pop_empty", 32'(f_empty), 1);
        chk("fwft_pop_vld",   32'(f_vld), 0);
        chk("reg_pop_dout",   32'(r_dout), 32'h00AA);

        // Reset mid-operation with 5 words, flags set, and we=re=1
        step(0, 0, 1, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, W'(16'h0200 + i));
        chk("pre_rst_unf", 32'(r_unf), 1);
        step(1, 1, 1, 0, 16'h0BAD);
        chk("rst_count", 32'(r_count), 0);
        chk("rst_empty", 32'(f_empty), 1);
        chk("rst_rvld",  32'(r_vld), 0);
        chk("rst_fvld",  32'(f_vld), 0);
        chk("rst_unf",   32'(r_unf), 0);
        chk("rst_rdout", 32'(r_dout), 0);
        chk("rst_fdout", 32'(f_dout), 0);

        // Randomized traffic alternating between fill-heavy and drain-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 150) % 2) ? 75 : 30;
            step($urandom_range(0, 999) < 3,
                 $urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 99) < 5,
                 W'($urandom));
        end

        rst = 1'b0; we = 1'b0; re = 1'b0; err_clr = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_param_fifo
